// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU execution controller.
// Holds the run-state encoding that also drives the mode LEDs.
// Imported by the controller top and its sub-modules.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN_S_IDLE = 2'b00,
    RUN_S_RUN  = 2'b01,
    RUN_S_HALT = 2'b10
  } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Key conditioner: 2-FF synchronizer, debounce counter, press detector.
// Latency: press fires DEBOUNCE_CYCLES+1 clk after the key first reads low.
// No backpressure: press is a 1-clk pulse on the debounced 1->0 edge only.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer and debounce state; released key is the reset level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = stable_q & ~stable_d;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller: step/run keys and CPU halt -> single-cycle cpu_ce pulses.
// Latency: cpu_ce is registered, one clk after a press or divider terminal count.
// No backpressure: halt_req freezes cpu_ce until rst; keys are ignored while halted.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 5000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_key,
  input  logic             run_key,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  logic             step_press;
  logic             run_press;
  run_state_e       state_q;
  run_state_e       state_d;
  logic [DW-1:0]    div_q;
  logic [DW-1:0]    div_d;
  logic             ce_q;
  logic             ce_d;
  logic [CNT_W-1:0] cnt_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .key_n (step_key),
    .press (step_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .rst   (rst),
    .key_n (run_key),
    .press (run_press)
  );

  // Next state: halt beats run press, run press beats step press and divider tick.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ce_d    = 1'b0;
    case (state_q)
      RUN_S_IDLE: begin
        if (halt_req) begin
          state_d = RUN_S_HALT;
        end else if (run_press) begin
          state_d = RUN_S_RUN;
          div_d   = '0;
        end else if (step_press) begin
          ce_d = 1'b1;
        end
      end
      RUN_S_RUN: begin
        if (halt_req) begin
          state_d = RUN_S_HALT;
        end else if (run_press) begin
          state_d = RUN_S_IDLE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          ce_d  = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      RUN_S_HALT: begin
        state_d = RUN_S_HALT;
      end
      default: begin
        state_d = RUN_S_IDLE;
        div_d   = '0;
      end
    endcase
  end

  // State, divider, registered enable and executed-step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN_S_IDLE;
      div_q   <= '0;
      ce_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ce_q    <= ce_d;
      if (ce_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cpu_ce     = ce_q;
  assign mode       = state_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with small parameters (debounce 4, divider 8, 4-bit count).
// Reference: window-based key acceptance plus mode/divider rules, updated per edge.
// Directed scenarios followed by a randomized key/halt/reset soak.
module tb_cpu_run_ctrl;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step_key = 1'b1;
  logic          run_key = 1'b1;
  logic          halt_req = 1'b0;
  logic          cpu_ce;
  logic [1:0]    mode;
  logic [CW-1:0] step_count;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV        (RD),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_key   (step_key),
    .run_key    (run_key),
    .halt_req   (halt_req),
    .cpu_ce     (cpu_ce),
    .mode       (mode),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: sampled key history, accepted key levels, mode, divider, enable, count.
  bit hs[$];
  bit hr[$];
  bit st_s = 1'b1;
  bit st_r = 1'b1;
  int m_mode = 0;
  int m_div  = 0;
  bit m_ce   = 1'b0;
  int m_cnt  = 0;

  // Observation bookkeeping.
  int cyc = 0;
  int dut_pulses = 0;
  int consec = 0;
  int pulse_q[$];
  int entry_cyc = -1;
  int exit_cyc = -1;
  bit prev_ce = 1'b0;
  logic [1:0] prev_mode = 2'b00;

  function automatic bit all_eq(input bit q[$], input bit v);
    for (int i = 0; i < D; i++) begin
      if (q[i] != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock edge of the reference. A key press is accepted when the last D
  // synchronized samples (keys seen two edges earlier and before) are all low
  // while the accepted level was high.
  function automatic void model_edge();
    bit ps;
    bit pr;
    bit nce;
    if (rst) begin
      hs = {};
      hr = {};
      for (int i = 0; i < D + 2; i++) begin
        hs.push_back(1'b1);
        hr.push_back(1'b1);
      end
      st_s = 1'b1; st_r = 1'b1;
      m_mode = 0; m_div = 0; m_ce = 1'b0; m_cnt = 0;
    end else begin
      hs.push_back(step_key); void'(hs.pop_front());
      hr.push_back(run_key);  void'(hr.pop_front());
      ps = st_s && all_eq(hs, 1'b0);
      pr = st_r && all_eq(hr, 1'b0);
      if (all_eq(hs, 1'b0)) st_s = 1'b0; else if (all_eq(hs, 1'b1)) st_s = 1'b1;
      if (all_eq(hr, 1'b0)) st_r = 1'b0; else if (all_eq(hr, 1'b1)) st_r = 1'b1;
      if (m_ce) m_cnt = (m_cnt + 1) % (1 << CW);
      nce = 1'b0;
      if (m_mode == 2) begin
        nce = 1'b0;
      end else if (halt_req) begin
        m_mode = 2;
      end else if (m_mode == 0) begin
        if (pr) begin m_mode = 1; m_div = 0; end
        else if (ps) nce = 1'b1;
      end else begin
        if (pr) begin m_mode = 0; m_div = 0; end
        else if (m_div == RD - 1) begin m_div = 0; nce = 1'b1; end
        else m_div = m_div + 1;
      end
      m_ce = nce;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (cpu_ce === 1'b1) begin
      dut_pulses++;
      pulse_q.push_back(cyc);
      if (prev_ce) consec++;
    end
    if (mode === 2'b01 && prev_mode === 2'b00) entry_cyc = cyc;
    if (mode === 2'b00 && prev_mode === 2'b01) exit_cyc = cyc;
    prev_ce = (cpu_ce === 1'b1);
    prev_mode = mode;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({cpu_ce, mode, step_count} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state: got ce=%b mode=%b cnt=%0d, want ce=0 mode=00 cnt=0", cpu_ce, mode, step_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if ({cpu_ce, mode, step_count} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d: got ce=%b mode=%b cnt=%0d, want all zero", cyc, cpu_ce, mode, step_count);
      end
    end
  endtask

  task automatic test_step();
    int p0;
    for (int k = 0; k < 16; k++) begin
      p0 = dut_pulses;
      for (int i = 0; i < 40; i++) begin
        step_key = (i < 20) ? 1'b0 : 1'b1;
        tick();
        n_cmp++;
        if ({cpu_ce, mode, step_count} !== {m_ce, 2'(m_mode), 4'(m_cnt)}) begin
          n_bad++;
          $display("FAIL step cyc=%0d: got ce=%b mode=%0d cnt=%0d, want ce=%b mode=%0d cnt=%0d",
                   cyc, cpu_ce, mode, step_count, m_ce, m_mode, m_cnt);
        end
      end
      n_cmp++;
      if (dut_pulses - p0 != 1) begin
        n_bad++;
        $display("FAIL step_one_pulse press=%0d: got %0d pulses, want 1", k, dut_pulses - p0);
      end
      if (k == 0) begin
        n_cmp++;
        if (step_count !== 4'd1) begin
          n_bad++;
          $display("FAIL step_count_first: got %0d, want 1", step_count);
        end
      end
    end
    n_cmp++;
    if (step_count !== 4'd0) begin
      n_bad++;
      $display("FAIL step_count_wrap: got %0d, want 0", step_count);
    end
    n_cmp++;
    if (consec != 0) begin
      n_bad++;
      $display("FAIL step_pulse_width: got %0d back-to-back pulses, want 0", consec);
    end
  endtask

  task automatic test_bounce();
    logic [CW-1:0] c0;
    int p0;
    c0 = step_count;
    p0 = dut_pulses;
    for (int i = 0; i < 14; i++) begin
      step_key = (i < 2) ? 1'b0 : 1'b1;
      tick();
      n_cmp++;
      if ({cpu_ce, mode, step_count} !== {m_ce, 2'(m_mode), 4'(m_cnt)}) begin
        n_bad++;
        $display("FAIL bounce cyc=%0d: got ce=%b mode=%0d cnt=%0d, want ce=%b mode=%0d cnt=%0d",
                 cyc, cpu_ce, mode, step_count, m_ce, m_mode, m_cnt);
      end
    end
    n_cmp++;
    if (step_count !== c0 || dut_pulses != p0) begin
      n_bad++;
      $display("FAIL bounce_no_pulse: got cnt=%0d pulses=%0d, want cnt=%0d pulses=0", step_count, dut_pulses - p0, c0);
    end
  endtask

  // Phases: run press, free run, step press (ignored), free run, run press, idle.
  task automatic test_run();
    int plan_s[6] = '{1, 1, 0, 1, 1, 1};
    int plan_r[6] = '{0, 1, 1, 1, 0, 1};
    int plan_n[6] = '{10, 40, 10, 30, 10, 30};
    bit bad_cad;
    pulse_q = {};
    entry_cyc = -1;
    exit_cyc = -1;
    for (int ph = 0; ph < 6; ph++) begin
      step_key = plan_s[ph][0];
      run_key  = plan_r[ph][0];
      for (int i = 0; i < plan_n[ph]; i++) begin
        tick();
        n_cmp++;
        if ({cpu_ce, mode, step_count} !== {m_ce, 2'(m_mode), 4'(m_cnt)}) begin
          n_bad++;
          $display("FAIL run cyc=%0d: got ce=%b mode=%0d cnt=%0d, want ce=%b mode=%0d cnt=%0d",
                   cyc, cpu_ce, mode, step_count, m_ce, m_mode, m_cnt);
        end
      end
    end
    n_cmp++;
    if (entry_cyc < 0 || exit_cyc < 0 || pulse_q.size() < 3) begin
      n_bad++;
      $display("FAIL run_cadence: got entry=%0d exit=%0d pulses=%0d, want run entry, exit and >=3 pulses",
               entry_cyc, exit_cyc, pulse_q.size());
    end else begin
      bad_cad = (pulse_q[0] - entry_cyc != RD) || (pulse_q[pulse_q.size()-1] >= exit_cyc)
                || (pulse_q[pulse_q.size()-1] + RD <= exit_cyc);
      for (int i = 1; i < pulse_q.size(); i++) begin
        if (pulse_q[i] - pulse_q[i-1] != RD) bad_cad = 1'b1;
      end
      if (bad_cad) begin
        n_bad++;
        $display("FAIL run_cadence: got first pulse %0d cycles after entry, %0d pulses, last=%0d exit=%0d; want first at %0d, spacing %0d, none after exit",
                 pulse_q[0] - entry_cyc, pulse_q.size(), pulse_q[pulse_q.size()-1], exit_cyc, RD, RD);
      end
    end
    n_cmp++;
    if (mode !== 2'b00) begin
      n_bad++;
      $display("FAIL run_stop_mode: got %b, want 00", mode);
    end
  endtask

  task automatic test_halt();
    int guard;
    int p0;
    run_key = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) run_key = 1'b1;
      tick();
    end
    guard = 0;
    while (m_div != RD - 1 && guard < 20) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 20 || mode !== 2'b01) begin
      n_bad++;
      $display("FAIL halt_setup: got mode=%b after %0d cycles, want mode=01 before terminal count", mode, guard);
    end
    halt_req = 1'b1;
    tick();
    n_cmp++;
    if (cpu_ce !== 1'b0 || mode !== 2'b10) begin
      n_bad++;
      $display("FAIL halt_on_tick: got ce=%b mode=%b, want ce=0 mode=10", cpu_ce, mode);
    end
    p0 = dut_pulses;
    for (int i = 0; i < 60; i++) begin
      step_key = (i % 30) < 12 ? 1'b0 : 1'b1;
      run_key  = (i % 20) < 8  ? 1'b0 : 1'b1;
      tick();
      n_cmp++;
      if ({cpu_ce, mode, step_count} !== {m_ce, 2'(m_mode), 4'(m_cnt)}) begin
        n_bad++;
        $display("FAIL halt_hold cyc=%0d: got ce=%b mode=%0d cnt=%0d, want ce=%b mode=%0d cnt=%0d",
                 cyc, cpu_ce, mode, step_count, m_ce, m_mode, m_cnt);
      end
    end
    n_cmp++;
    if (dut_pulses != p0 || mode !== 2'b10) begin
      n_bad++;
      $display("FAIL halt_keys_ignored: got %0d pulses mode=%b, want 0 pulses mode=10", dut_pulses - p0, mode);
    end
    step_key = 1'b1;
    run_key  = 1'b1;
    halt_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({cpu_ce, mode, step_count} !== 7'b0) begin
      n_bad++;
      $display("FAIL halt_reset_exit: got ce=%b mode=%b cnt=%0d, want all zero", cpu_ce, mode, step_count);
    end
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    pulse_q = {};
    entry_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      step_key = (i < 10) ? 1'b0 : 1'b1;
      run_key  = (i < 10) ? 1'b0 : 1'b1;
      tick();
      n_cmp++;
      if ({cpu_ce, mode, step_count} !== {m_ce, 2'(m_mode), 4'(m_cnt)}) begin
        n_bad++;
        $display("FAIL simul cyc=%0d: got ce=%b mode=%0d cnt=%0d, want ce=%b mode=%0d cnt=%0d",
                 cyc, cpu_ce, mode, step_count, m_ce, m_mode, m_cnt);
      end
    end
    n_cmp++;
    if (entry_cyc < 0 || pulse_q.size() == 0 || pulse_q[0] - entry_cyc != RD) begin
      n_bad++;
      $display("FAIL simul_first_pulse: got entry=%0d pulses=%0d first=%0d, want first pulse %0d cycles after entry",
               entry_cyc, pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1, RD);
    end
    n_cmp++;
    if (mode !== 2'b01) begin
      n_bad++;
      $display("FAIL simul_mode: got %b, want 01", mode);
    end
  endtask

  task automatic test_random();
    int hold_s = 1;
    int hold_r = 1;
    int hold_h = 0;
    for (int i = 0; i < 900; i++) begin
      if (--hold_s <= 0) begin step_key = ~step_key; hold_s = $urandom_range(1, 12); end
      if (--hold_r <= 0) begin run_key = ~run_key; hold_r = $urandom_range(4, 40); end
      if (hold_h > 0) hold_h--;
      halt_req = (hold_h > 0 && hold_h < 5) ? 1'b1 : 1'b0;
      if (hold_h == 0 && $urandom_range(0, 299) == 0) hold_h = 60;
      rst = ($urandom_range(0, 149) == 0 || hold_h == 1) ? 1'b1 : 1'b0;
      tick();
      n_cmp++;
      if ({cpu_ce, mode, step_count} !== {m_ce, 2'(m_mode), 4'(m_cnt)}) begin
        n_bad++;
        $display("FAIL random cyc=%0d: got ce=%b mode=%0d cnt=%0d, want ce=%b mode=%0d cnt=%0d",
                 cyc, cpu_ce, mode, step_count, m_ce, m_mode, m_cnt);
      end
    end
    rst = 1'b0;
    halt_req = 1'b0;
    n_cmp++;
    if (consec != 0) begin
      n_bad++;
      $display("FAIL random_pulse_width: got %0d back-to-back pulses, want 0", consec);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_step();
    test_bounce();
    test_run();
    test_halt();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
